// File: rtl/nf_fetch_unit_pkg.sv
// Shared types and constants for the nanoFOX instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state encoding, reset PC default, queue entry struct, word-align helper.
package nf_fetch_unit_pkg;

  // FETCH: normal fetching. DROP: one response is still owed by memory and must be discarded.
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DROP  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One queued instruction and the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/nf_fetch_fifo.sv
// Two-entry in-order queue of fetched {pc, instr} words; head is always entry 0.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full unless a pop frees space in the same cycle; flush wins.
// Ports: clk/resetn; push/push_dat in; pop, flush in; head_dat, count, full, empty out.
module nf_fetch_fifo
  import nf_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_dat,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t e0_q, e0_d;
  fetch_entry_t e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         empty_q, empty_d;
  logic         pop_ok, push_ok;

  assign pop_ok  = pop && (cnt_q != 2'd0);
  assign push_ok = push && ((cnt_q != 2'd2) || pop_ok);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = push_dat;
          else               e1_d = push_dat;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever survives the pop.
          if (cnt_q == 2'd1) begin
            e0_d = push_dat;
          end else begin
            e0_d = e1_q;
            e1_d = push_dat;
          end
        end
        default: ;
      endcase
    end
    empty_d = (cnt_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      e0_q    <= '0;
      e1_q    <= '0;
      cnt_q   <= 2'd0;
      empty_q <= 1'b1;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
    end
  end

  assign head_dat = e0_q;
  assign count    = cnt_q;
  assign full     = (cnt_q == 2'd2);
  assign empty    = empty_q;

endmodule

// File: rtl/nf_fetch_unit.sv
// Instruction fetch: owns the fetch PC, one outstanding imem read, a 2-entry queue to decode.
// Latency: imem_ack in cycle N gives instr_valid in cycle N+1; zero-wait memory sustains 1 instr/cycle.
// Backpressure: instr_ready low fills the queue, then imem_req drops until space frees.
// Ports: clk, resetn; imem_addr/imem_req out, imem_ack/imem_rdata in; branch_en/branch_target in;
//        instr/instr_pc/instr_valid out, instr_ready in.
module nf_fetch_unit
  import nf_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic         inflight_q, inflight_d;
  // Low for the first cycle after reset so no request is ever driven while resetn is held.
  logic         run_q, run_d;

  fetch_entry_t push_dat, head_dat;
  logic [1:0]   fifo_count;
  logic         fifo_full, fifo_empty;
  logic         ack_hit, push, pop;

  // Request depends only on flops: an un-acked request is held, otherwise ask while room remains.
  assign imem_req  = run_q && ((state_q == ST_DROP) || inflight_q || (fifo_count < 2'd2));
  assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;

  assign ack_hit  = imem_req && imem_ack;
  assign push     = (state_q == ST_FETCH) && ack_hit && !branch_en && (!fifo_full || pop);
  assign pop      = instr_valid && instr_ready;
  assign push_dat = '{pc: fetch_pc_q, instr: imem_rdata};

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    run_d       = 1'b1;
    inflight_d  = imem_req && !imem_ack;
    case (state_q)
      ST_FETCH: begin
        if (branch_en) begin
          fetch_pc_d = word_align(branch_target);
          // Memory still owes us a word for the old address: keep asking for it, then discard.
          if (imem_req && !imem_ack) begin
            state_d     = ST_DROP;
            drop_addr_d = fetch_pc_q;
          end
        end else if (push) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      ST_DROP: begin
        if (branch_en) fetch_pc_d = word_align(branch_target);
        if (ack_hit)   state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_FETCH;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      inflight_q  <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      inflight_q  <= inflight_d;
      run_q       <= run_d;
    end
  end

  nf_fetch_fifo u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (branch_en),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign instr       = head_dat.instr;
  assign instr_pc    = head_dat.pc;
  assign instr_valid = !fifo_empty;

endmodule

// File: tb/tb_nf_fetch_unit.sv
module tb_nf_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        resetn;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_en;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks;
  int failures;
  int wait_cnt;
  int mem_lat;
  bit mem_auto;
  logic [63:0] pop_q[$];
  logic [31:0] ack_q[$];

  nf_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Log this cycle's handshakes, advance one clock, then let the memory model answer.
  task automatic step();
    if (instr_valid === 1'b1 && instr_ready === 1'b1) pop_q.push_back({instr_pc, instr});
    if (imem_req === 1'b1 && imem_ack === 1'b1) ack_q.push_back(imem_addr);
    @(posedge clk);
    #1;
    if (mem_auto) begin
      if (imem_req === 1'b1) begin
        if (wait_cnt == mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ K;
          wait_cnt   = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; instr_ready = 1'b1; branch_en = 1'b0; branch_target = '0;
    imem_ack = 1'b0; imem_rdata = '0; mem_auto = 1'b1; mem_lat = 0; wait_cnt = 0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL reset_addr got=%h exp=00000100", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h/%h exp=0/0", instr, instr_pc); end
    resetn = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL first_req got=%b/%h exp=1/00000100", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL first_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i] || instr !== (exp_pc[i] ^ K)) begin
        failures++; $display("FAIL stream_instr%0d got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr_pc, instr, exp_pc[i], exp_pc[i] ^ K);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc[i] + 32'd4) begin
        failures++; $display("FAIL stream_addr%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, exp_pc[i] + 32'd4);
      end
    end
  endtask

  task automatic test_backpressure();
    ack_q.delete(); pop_q.delete();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req got=%b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h108) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/00000108", instr_valid, instr_pc); end
    checks++; if (ack_q.size() != 1 || ack_q[0] !== 32'h10C) begin failures++; $display("FAIL bp_acks got=%0d exp=1 (10c)", ack_q.size()); end
    instr_ready = 1'b1; mem_lat = 3;
    step();
    checks++; if (instr_pc !== 32'h10C || instr_valid !== 1'b1) begin failures++; $display("FAIL bp_resume_head got=%b/%h exp=1/0000010c", instr_valid, instr_pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin failures++; $display("FAIL bp_resume_req got=%b/%h exp=1/00000110", imem_req, imem_addr); end
    checks++; if (pop_q.size() != 1 || pop_q[0][63:32] !== 32'h108) begin failures++; $display("FAIL bp_pop_order got=%0d exp=1 (108)", pop_q.size()); end
  endtask

  task automatic test_branch_drop();
    step();
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h110 || imem_ack !== 1'b0) begin failures++; $display("FAIL drop_pre got=%b/%h/%b exp=0/00000110/0", instr_valid, imem_addr, imem_ack); end
    branch_en = 1'b1; branch_target = 32'h203;
    step();
    branch_en = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h110 || instr_valid !== 1'b0) begin failures++; $display("FAIL drop_hold got=%b/%h/%b exp=1/00000110/0", imem_req, imem_addr, instr_valid); end
    step();
    checks++; if (imem_addr !== 32'h110 || imem_ack !== 1'b1) begin failures++; $display("FAIL drop_ack got=%h/%b exp=00000110/1", imem_addr, imem_ack); end
    mem_lat = 0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin failures++; $display("FAIL drop_target_req got=%b/%h/%b exp=1/00000200/0", imem_req, imem_addr, instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== (32'h200 ^ K)) begin failures++; $display("FAIL drop_first_instr got=%b/%h/%h exp=1/00000200", instr_valid, instr_pc, instr); end
    checks++; if (pop_q.size() != 2 || pop_q[1][63:32] !== 32'h10C) begin failures++; $display("FAIL drop_no_stale got=%0d exp=2", pop_q.size()); end
  endtask

  task automatic test_branch_with_ack();
    pop_q.delete();
    checks++; if (imem_ack !== 1'b1 || imem_addr !== 32'h204) begin failures++; $display("FAIL bwa_setup got=%b/%h exp=1/00000204", imem_ack, imem_addr); end
    branch_en = 1'b1; branch_target = 32'h300;
    step();
    branch_en = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL bwa_req got=%b/%b/%h exp=0/1/00000300", instr_valid, imem_req, imem_addr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin failures++; $display("FAIL bwa_instr got=%b/%h exp=1/00000300", instr_valid, instr_pc); end
    checks++; if (pop_q.size() != 1 || pop_q[0][63:32] !== 32'h200) begin failures++; $display("FAIL bwa_pops got=%0d exp=1 (200)", pop_q.size()); end
  endtask

  task automatic test_double_branch();
    pop_q.delete();
    mem_lat = 3;
    step();
    checks++; if (instr_pc !== 32'h304 || imem_addr !== 32'h308 || imem_ack !== 1'b0) begin failures++; $display("FAIL dbl_setup got=%h/%h/%b exp=00000304/00000308/0", instr_pc, imem_addr, imem_ack); end
    branch_en = 1'b1; branch_target = 32'h3F0;
    step();
    branch_target = 32'h400;
    step();
    branch_target = 32'h501;
    step();
    branch_en = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h308 || instr_valid !== 1'b0) begin failures++; $display("FAIL dbl_hold got=%b/%h/%b exp=1/00000308/0", imem_req, imem_addr, instr_valid); end
    mem_lat = 0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h500) begin failures++; $display("FAIL dbl_target got=%b/%h exp=1/00000500", imem_req, imem_addr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h500) begin failures++; $display("FAIL dbl_instr got=%b/%h exp=1/00000500", instr_valid, instr_pc); end
    checks++; if (pop_q.size() != 2 || pop_q[1][63:32] !== 32'h304) begin failures++; $display("FAIL dbl_pops got=%0d exp=2", pop_q.size()); end
  endtask

  task automatic test_reset_midflight();
    mem_lat = 5;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h508 || imem_ack !== 1'b0) begin failures++; $display("FAIL rst_setup got=%b/%h/%b exp=1/00000508/0", imem_req, imem_addr, imem_ack); end
    resetn = 1'b0; mem_auto = 1'b0; imem_ack = 1'b0;
    step();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin failures++; $display("FAIL rst_state got=%b/%h/%b exp=0/00000100/0", imem_req, imem_addr, instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    resetn = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin failures++; $display("FAIL rst_restart got=%b/%h/%b exp=1/00000100/0", imem_req, imem_addr, instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'h100 ^ K;
    step();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== (32'h100 ^ K)) begin failures++; $display("FAIL rst_first_instr got=%b/%h/%h exp=1/00000100/%h", instr_valid, instr_pc, instr, 32'h100 ^ K); end
    checks++; if (imem_addr !== 32'h104) begin failures++; $display("FAIL rst_next_addr got=%h exp=00000104", imem_addr); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_drop();
    test_branch_with_ack();
    test_double_branch();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
